// File: rtl/vec_lsu.sv
// Vector load/store unit: serialises a LANES x ELEM_W register access into byte-wide memory beats.
// Optional macro VLSU_STRIDE_EN adds a runtime element stride; without it elements are contiguous.
module vec_lsu #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 6,
  parameter int ELEM_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         is_store,
  input  logic                         is_scalar,
  input  logic [ADDR_W-1:0]            base_addr,
`ifdef VLSU_STRIDE_EN
  input  logic [7:0]                   stride,
`endif
  input  logic [3:0]                   dest_reg,
  input  logic [LANES-1:0][ELEM_W-1:0] store_data,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [ELEM_W-1:0]            mem_wdata,
  input  logic [ELEM_W-1:0]            mem_rdata,
  output logic                         rf_we,
  output logic                         rf_sflag,
  output logic                         rf_ldflag,
  output logic [3:0]                   rf_a3,
  output logic [LANES-1:0][ELEM_W-1:0] rf_wd
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WB, FIN} state_t;

  state_t                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             last_q;
  logic [ADDR_W-1:0]            addr_q;
  logic                         we_q;
  logic [ELEM_W-1:0]            wdata_q;
  logic                         rfwe_q;
  logic                         sflag_q;
  logic                         ldflag_q;
  logic                         done_q;
  logic                         st_q;
  logic                         scalar_q;
  logic                         bad_q;
  logic [3:0]                   dest_q;
  logic [LANES-1:0][ELEM_W-1:0] store_q;
  logic [LANES-1:0][ELEM_W-1:0] buf_q;
  logic [7:0]                   stride_eff;

`ifdef VLSU_STRIDE_EN
  logic [7:0] stride_q;
  assign stride_eff = stride_q;
`else
  assign stride_eff = 8'd1;
`endif

  // Accept-time decode of the incoming request.
  logic              bad_d;
  logic [ELEM_W-1:0] wdata_d;
  logic [IDX_W-1:0]  last_d;
  logic [ADDR_W-1:0] addr_d;
  logic [IDX_W-1:0]  idx_nx;
  logic [IDX_W-1:0]  idx_pv;

  always_comb begin
    bad_d   = is_scalar && (dest_reg >= 4'(LANES));
    wdata_d = store_data[0];
    if (is_scalar) begin
      wdata_d = bad_d ? '0 : store_data[dest_reg[IDX_W-1:0]];
    end
    last_d  = is_scalar ? '0 : IDX_W'(LANES - 1);
    addr_d  = addr_q + ADDR_W'(stride_eff);
    idx_nx  = idx_q + ONE;
    idx_pv  = idx_q - ONE;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign rf_we     = rfwe_q;
  assign rf_sflag  = sflag_q;
  assign rf_ldflag = ldflag_q;
  assign rf_a3     = dest_q;
  assign rf_wd     = buf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rfwe_q   <= 1'b0;
      sflag_q  <= 1'b0;
      ldflag_q <= 1'b0;
      done_q   <= 1'b0;
      st_q     <= 1'b0;
      scalar_q <= 1'b0;
      bad_q    <= 1'b0;
      dest_q   <= '0;
      store_q  <= '0;
      buf_q    <= '0;
`ifdef VLSU_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          rfwe_q   <= 1'b0;
          sflag_q  <= 1'b0;
          ldflag_q <= 1'b0;
          if (start) begin
            st_q     <= is_store;
            scalar_q <= is_scalar;
            bad_q    <= bad_d;
            dest_q   <= dest_reg;
            store_q  <= store_data;
            last_q   <= last_d;
            idx_q    <= '0;
            buf_q    <= '0;
            addr_q   <= base_addr;
            we_q     <= is_store && !bad_d;
            wdata_q  <= wdata_d;
`ifdef VLSU_STRIDE_EN
            stride_q <= stride;
`endif
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // Read data lags its address by one cycle, so this beat lands in the previous lane.
          if (!st_q && idx_q != '0) begin
            buf_q[idx_pv] <= mem_rdata;
          end
          if (idx_q == last_q) begin
            we_q <= 1'b0;
            if (st_q) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            idx_q   <= idx_nx;
            addr_q  <= addr_d;
            wdata_q <= store_q[idx_nx];
          end
        end
        DRAIN: begin
          buf_q[last_q] <= mem_rdata;
          done_q        <= 1'b1;
          rfwe_q        <= !bad_q;
          sflag_q       <= scalar_q;
          ldflag_q      <= 1'b1;
          state_q       <= WB;
        end
        WB: begin
          done_q   <= 1'b0;
          rfwe_q   <= 1'b0;
          sflag_q  <= 1'b0;
          ldflag_q <= 1'b0;
          state_q  <= IDLE;
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
